multicycle_core: RTL and testbench
==================================

// Module: multicycle_core
// PURPOSE
//  Parametrised multi-cycle reduced RV32 core; successor to the single-cycle top.
//  One FSM sequences fetch/decode/execute/memory/writeback over a single unified memory port
//  with a req/ready handshake, so wait-stated memory is tolerated.
//  Integer ISA: ADD, SUB, ADDI, LUI, BEQ, BNE, JAL, LW, SW. Contains its own register file and ALU.
//  a0 (x10) is exported for bring-up.
// PARAMETERS
//  XLEN       32     datapath width; only 32 is legal (elaboration error otherwise)
//  RESET_PC   32'h0  PC loaded on reset
//  REG_COUNT  32     architectural registers: 32 (RV32I) or 16 (RV32E); any other value is an elaboration error
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst        in   1     synchronous, active-high reset
//  mem_req    out  1     memory access request
//  mem_we     out  1     1 = store, 0 = load/fetch
//  mem_addr   out  XLEN  byte address, word aligned
//  mem_wdata  out  XLEN  store data
//  mem_rdata  in   XLEN  read data, valid in the cycle mem_ready=1
//  mem_ready  in   1     access completes in any cycle where mem_req=1 and mem_ready=1
//  a0         out  XLEN  current value of x10
//  retire     out  1     1-cycle pulse when an instruction completes
//  halted     out  1     sticky; set on illegal or misaligned instruction
// BEHAVIOUR
//  Reset: while rst is sampled high the state goes to FETCH and PC to RESET_PC; all registers clear to 0.
//    Outputs during and after reset: mem_req=0 in any cycle rst is high, mem_we=0, mem_addr=RESET_PC,
//    mem_wdata=0, a0=0, retire=0, halted=0.
//    rst mid-instruction aborts it: no register, PC or memory write occurs.
//  States:
//   FETCH  - req at PC. Stays while !mem_ready; on ready latches IR, goes to DECODE.
//   DECODE - reads rs1/rs2 and generates the immediate (I/S/B/U/J). Checks legality:
//            bad opcode/funct, or any used reg index >= REG_COUNT -> HALT. Otherwise -> EXEC.
//   EXEC   - ALU result, or branch compare and target.
//            BEQ/BNE: PC<=taken ? PC+immB : PC+4, retire=1, -> FETCH.
//            Branch target misaligned (bits[1:0]!=0) -> HALT, PC unchanged.
//            LW/SW: address=rs1+immI/S; misaligned -> HALT, else -> MEM.
//            Others -> WB.
//   MEM    - req with we=SW. Addr/wdata/we stay stable until ready.
//            SW on ready: PC+=4, retire, -> FETCH. LW on ready: latch rdata -> WB.
//   WB     - rd<=result (ALU, LUI imm, JAL PC+4, LW data). Writes to x0 are dropped.
//            PC<=JAL ? PC+immJ : PC+4. JAL target misaligned -> HALT, no write. retire=1, -> FETCH.
//   HALT   - mem_req=0, halted=1, retire=0; exits only via rst.
//  Latency with zero wait states: branch 3, ALU/LUI/JAL 4, SW 4, LW 5 cycles.
//    Each cycle mem_ready is low in FETCH/MEM adds 1.
//  Arithmetic is modulo 2^XLEN. Branch compare is 32-bit equality.
//    Immediates are sign-extended (LUI: imm<<12).
//  Register write and PC update take effect at the same edge; the next FETCH uses the new PC.
//    A write to x10 is visible on a0 the cycle after WB.
//  mem_ready when mem_req=0 is ignored. Unused mem_rdata bits are ignored.
// TESTING
//  1. rst=1 for 2 cycles, then 0 -> mem_req=0 during rst; next cycle mem_req=1, mem_addr=0x0,
//     mem_we=0, a0=0, halted=0.
//  2. Fetch 0x00500513 (addi x10,x0,5), zero wait -> retire in 4th cycle, a0=5 next cycle,
//     next fetch at 0x4.
//  3. addi x5,x0,0x40; addi x6,x0,-7; sw x6,0(x5); lw x10,0(x5) -> one cycle with mem_we=1,
//     addr=0x40, wdata=0xFFFFFFF9; final a0=0xFFFFFFF9; lw takes 5 cycles.
//  4. mem_ready low 3 cycles during a fetch -> mem_req, mem_addr, mem_we held constant;
//     instruction retires 3 cycles later than in test 2.
//  5. Loop: addi x10,x10,1; addi x11,x0,3; bne x10,x11,-8 -> bne taken twice then not taken;
//     a0=3; 9 retires before the fetch at 0xC.
//  6. Fetch 0x00000000 -> halted=1, mem_req=0, no retire.
//     REG_COUNT=16 with addi x20,x0,1 -> HALT.
//     Then rst -> fetch resumes at RESET_PC.

Source files
------------

// File: rtl/multicycle_core_if.sv
// Unified memory port of the multi-cycle core: one req/ready handshake shared by
// instruction fetch, loads and stores.
interface multicycle_core_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle reduced RV32 core (ADD SUB ADDI LUI BEQ BNE JAL LW SW) with its own
// register file and ALU, sequenced by one FSM over a single wait-stated memory port.
//
// state  | meaning
// FETCH  | request word at PC, latch IR on ready
// DECODE | read operands, build immediate, check legality
// EXEC   | ALU / branch resolve / load-store address
// MEM    | data access, held stable until ready
// WB     | register write and PC update
// HALT   | stopped after illegal or misaligned instruction, left only by rst
module multicycle_core #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              REG_COUNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_core_if.master bus,
    output logic [XLEN-1:0]   a0,
    output logic              retire,
    output logic              halted
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("multicycle_core: XLEN must be 32");
    end
    if (REG_COUNT != 32 && REG_COUNT != 16) begin : g_bad_reg_count
        $error("multicycle_core: REG_COUNT must be 16 or 32");
    end

    localparam int RIDX = (REG_COUNT == 16) ? 4 : 5;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_ADDI, OP_LUI, OP_BEQ, OP_BNE, OP_JAL, OP_LW, OP_SW
    } op_t;

    state_t          state;
    op_t             op_q;
    logic [XLEN-1:0] pc, ir, rs1_q, rs2_q, imm_q, result_q, next_pc_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] regs [REG_COUNT];

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd_idx, rs1_idx, rs2_idx;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign opcode  = ir[6:0];
    assign rd_idx  = ir[11:7];
    assign funct3  = ir[14:12];
    assign rs1_idx = ir[19:15];
    assign rs2_idx = ir[24:20];
    assign funct7  = ir[31:25];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // Out-of-range indices only alias here; DECODE sends them to HALT before use.
    assign rs1_val = regs[rs1_idx[RIDX-1:0]];
    assign rs2_val = regs[rs2_idx[RIDX-1:0]];

    function automatic logic reg_bad(input logic [4:0] idx);
        return 32'(idx) >= 32'(REG_COUNT);
    endfunction

    op_t             dec_op;
    logic            dec_ok, use_rd, use_rs1, use_rs2;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        dec_op  = OP_ADD;
        dec_ok  = 1'b1;
        dec_imm = '0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            7'b0110011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (funct3 == 3'b000 && funct7 == 7'b0000000)      dec_op = OP_ADD;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_op = OP_SUB;
                else                                                dec_ok = 1'b0;
            end
            7'b0010011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                dec_op  = OP_ADDI;
                dec_imm = imm_i;
                dec_ok  = (funct3 == 3'b000);
            end
            7'b0110111: begin
                use_rd  = 1'b1;
                dec_op  = OP_LUI;
                dec_imm = imm_u;
            end
            7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_imm = imm_b;
                if (funct3 == 3'b000)      dec_op = OP_BEQ;
                else if (funct3 == 3'b001) dec_op = OP_BNE;
                else                       dec_ok = 1'b0;
            end
            7'b1101111: begin
                use_rd  = 1'b1;
                dec_op  = OP_JAL;
                dec_imm = imm_j;
            end
            7'b0000011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                dec_op  = OP_LW;
                dec_imm = imm_i;
                dec_ok  = (funct3 == 3'b010);
            end
            7'b0100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_op  = OP_SW;
                dec_imm = imm_s;
                dec_ok  = (funct3 == 3'b010);
            end
            default: dec_ok = 1'b0;
        endcase
        if ((use_rd && reg_bad(rd_idx)) || (use_rs1 && reg_bad(rs1_idx)) ||
            (use_rs2 && reg_bad(rs2_idx)))
            dec_ok = 1'b0;
    end

    logic [XLEN-1:0] alu_out, pc_plus4, br_target;
    logic            is_branch, br_taken, br_bad, jal_bad;

    always_comb begin
        alu_out = rs1_q + imm_q;
        case (op_q)
            OP_ADD:  alu_out = rs1_q + rs2_q;
            OP_SUB:  alu_out = rs1_q - rs2_q;
            OP_LUI:  alu_out = imm_q;
            OP_JAL:  alu_out = pc_plus4;
            default: alu_out = rs1_q + imm_q;
        endcase
    end

    assign pc_plus4  = pc + XLEN'(4);
    assign br_target = pc + imm_q;
    assign is_branch = (op_q == OP_BEQ) || (op_q == OP_BNE);
    assign br_taken  = (rs1_q == rs2_q) ^ (op_q == OP_BNE);
    assign br_bad    = br_taken && (br_target[1:0] != 2'b00);
    assign jal_bad   = (op_q == OP_JAL) && (next_pc_q[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            op_q      <= OP_ADD;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            result_q  <= '0;
            next_pc_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir    <= bus.mem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_q  <= dec_op;
                    rd_q  <= rd_idx;
                    rs1_q <= rs1_val;
                    rs2_q <= rs2_val;
                    imm_q <= dec_imm;
                    state <= dec_ok ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    if (is_branch) begin
                        if (br_bad) begin
                            state <= S_HALT;
                        end else begin
                            pc    <= br_taken ? br_target : pc_plus4;
                            state <= S_FETCH;
                        end
                    end else if (op_q == OP_LW || op_q == OP_SW) begin
                        result_q <= alu_out;
                        state    <= (alu_out[1:0] != 2'b00) ? S_HALT : S_MEM;
                    end else begin
                        result_q  <= alu_out;
                        next_pc_q <= (op_q == OP_JAL) ? br_target : pc_plus4;
                        state     <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        if (op_q == OP_SW) begin
                            pc    <= pc_plus4;
                            state <= S_FETCH;
                        end else begin
                            result_q  <= bus.mem_rdata;
                            next_pc_q <= pc_plus4;
                            state     <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (jal_bad) begin
                        state <= S_HALT;
                    end else begin
                        if (rd_q != 5'd0) regs[rd_q[RIDX-1:0]] <= result_q;
                        pc    <= next_pc_q;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Outputs are masked by rst so they hold reset values even in the first reset cycle.
    logic store_active;
    assign store_active  = !rst && (state == S_MEM) && (op_q == OP_SW);
    assign bus.mem_req   = !rst && (state == S_FETCH || state == S_MEM);
    assign bus.mem_we    = store_active;
    assign bus.mem_addr  = rst ? RESET_PC : ((state == S_MEM) ? result_q : pc);
    assign bus.mem_wdata = store_active ? rs2_q : '0;
    assign a0            = rst ? '0 : regs[10];
    assign halted        = !rst && (state == S_HALT);

    always_comb begin
        retire = 1'b0;
        if (!rst) begin
            case (state)
                S_EXEC:  retire = is_branch && !br_bad;
                S_MEM:   retire = (op_q == OP_SW) && bus.mem_ready;
                S_WB:    retire = !jal_bad;
                default: retire = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small programs in a behavioural memory,
// per-cycle trace, hand-computed timing and register expectations.
module tb_multicycle_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_core_if #(.XLEN(32)) bus ();
    multicycle_core_if #(.XLEN(32)) bus16 ();

    logic [31:0] a0, a0_16;
    logic        retire, halted, retire16, halted16;

    multicycle_core #(.XLEN(32), .RESET_PC(32'h0), .REG_COUNT(32)) dut (
        .clk(clk), .rst(rst), .bus(bus), .a0(a0), .retire(retire), .halted(halted)
    );

    multicycle_core #(.XLEN(32), .RESET_PC(32'h0), .REG_COUNT(16)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16), .a0(a0_16), .retire(retire16), .halted(halted16)
    );

    // program words at 0x00-0x3C, data words at 0x40-0x7C, NOP elsewhere
    logic [31:0] prog [16];
    logic [31:0] dmem [16];
    int          stall_cycles;
    int          stall_cnt = 0;
    logic [31:0] rdata16;

    assign bus.mem_ready = (stall_cnt >= stall_cycles);
    assign bus.mem_rdata = (bus.mem_addr < 32'h40) ? prog[bus.mem_addr[5:2]] :
                           (bus.mem_addr < 32'h80) ? dmem[bus.mem_addr[5:2]] : 32'h00000013;
    assign bus16.mem_ready = 1'b1;
    assign bus16.mem_rdata = rdata16;

    always @(posedge clk) begin
        if (rst) stall_cnt <= 0;
        else if (bus.mem_req && !bus.mem_ready) stall_cnt <= stall_cnt + 1;
        if (bus.mem_req && bus.mem_we && bus.mem_ready &&
            bus.mem_addr >= 32'h40 && bus.mem_addr < 32'h80)
            dmem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end

    int checks = 0;
    int errors = 0;

    logic        req_log [64], we_log [64], ret_log [64], halt_log [64];
    logic [31:0] addr_log [64], wdata_log [64], a0_log [64];

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 32'h00000013;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
    endtask

    // cycle 1 is the cycle in progress when called
    task automatic run_trace(input int ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            req_log[c]   = bus.mem_req;
            we_log[c]    = bus.mem_we;
            addr_log[c]  = bus.mem_addr;
            wdata_log[c] = bus.mem_wdata;
            ret_log[c]   = retire;
            halt_log[c]  = halted;
            a0_log[c]    = a0;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL reset_req_cycle1: got %0b expected 0", bus.mem_req);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 ||
            bus.mem_wdata !== 32'h0 || a0 !== 32'h0 || retire !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%0b we=%0b addr=%h wdata=%h a0=%h ret=%0b halt=%0b expected all 0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, a0, retire, halted);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0 ||
            a0 !== 32'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_fetch: got req=%0b addr=%h we=%0b a0=%h halt=%0b expected req=1 addr=0",
                     bus.mem_req, bus.mem_addr, bus.mem_we, a0, halted);
        end
    endtask

    task automatic test_addi();
        int first = 0;
        clear_prog();
        prog[0] = 32'h00500513;             // addi x10,x0,5
        do_reset();
        run_trace(6);
        for (int c = 1; c <= 6; c++) if (ret_log[c] && first == 0) first = c;
        checks++;
        if (first !== 4) begin
            errors++; $display("FAIL addi_retire_cycle: got %0d expected 4", first);
        end
        checks++;
        if (a0_log[4] !== 32'h0 || a0_log[5] !== 32'h5) begin
            errors++; $display("FAIL addi_a0: got %h/%h expected 0/5", a0_log[4], a0_log[5]);
        end
        checks++;
        if (req_log[5] !== 1'b1 || addr_log[5] !== 32'h4) begin
            errors++; $display("FAIL addi_next_fetch: got req=%0b addr=%h expected 1/00000004",
                               req_log[5], addr_log[5]);
        end
    endtask

    task automatic test_store_load();
        int nwe = 0;
        int we_at = 0;
        int next_ret = 0;
        clear_prog();
        prog[0] = 32'h04000293;             // addi x5,x0,0x40
        prog[1] = 32'hFF900313;             // addi x6,x0,-7
        prog[2] = 32'h0062A023;             // sw x6,0(x5)
        prog[3] = 32'h0002A503;             // lw x10,0(x5)
        do_reset();
        run_trace(19);
        for (int c = 1; c <= 19; c++) if (we_log[c]) begin nwe++; we_at = c; end
        checks++;
        if (nwe !== 1 || we_at !== 12) begin
            errors++; $display("FAIL sw_we_cycles: got count=%0d at=%0d expected 1 at 12", nwe, we_at);
        end
        checks++;
        if (addr_log[12] !== 32'h40 || wdata_log[12] !== 32'hFFFFFFF9 || ret_log[12] !== 1'b1) begin
            errors++; $display("FAIL sw_bus: got addr=%h wdata=%h ret=%0b expected 00000040/fffffff9/1",
                               addr_log[12], wdata_log[12], ret_log[12]);
        end
        checks++;
        if (req_log[16] !== 1'b1 || we_log[16] !== 1'b0 || addr_log[16] !== 32'h40) begin
            errors++; $display("FAIL lw_mem_access: got req=%0b we=%0b addr=%h expected 1/0/00000040",
                               req_log[16], we_log[16], addr_log[16]);
        end
        for (int c = 13; c <= 19; c++) if (ret_log[c] && next_ret == 0) next_ret = c;
        checks++;
        if (next_ret - 12 !== 5) begin
            errors++; $display("FAIL lw_latency: got %0d expected 5", next_ret - 12);
        end
        checks++;
        if (a0_log[18] !== 32'hFFFFFFF9 || dmem[0] !== 32'hFFFFFFF9) begin
            errors++; $display("FAIL lw_result: got a0=%h mem=%h expected fffffff9", a0_log[18], dmem[0]);
        end
    endtask

    task automatic test_wait_states();
        int first = 0;
        clear_prog();
        prog[0] = 32'h00500513;
        stall_cycles = 3;
        do_reset();
        run_trace(9);
        stall_cycles = 0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (req_log[c] !== 1'b1 || addr_log[c] !== 32'h0 || we_log[c] !== 1'b0) begin
                errors++; $display("FAIL stall_hold_c%0d: got req=%0b addr=%h we=%0b expected 1/0/0",
                                   c, req_log[c], addr_log[c], we_log[c]);
            end
        end
        for (int c = 1; c <= 9; c++) if (ret_log[c] && first == 0) first = c;
        checks++;
        if (first !== 7 || a0_log[8] !== 32'h5) begin
            errors++; $display("FAIL stall_retire: got cycle=%0d a0=%h expected 7/00000005", first, a0_log[8]);
        end
    endtask

    task automatic test_loop();
        int fetch_c = 0;
        int rets = 0;
        int zero_fetches = 0;
        clear_prog();
        prog[0] = 32'h00150513;             // addi x10,x10,1
        prog[1] = 32'h00300593;             // addi x11,x0,3
        prog[2] = 32'hFEB51CE3;             // bne x10,x11,-8
        do_reset();
        run_trace(40);
        for (int c = 1; c <= 40; c++) begin
            if (req_log[c] && !we_log[c] && addr_log[c] == 32'hC && fetch_c == 0) fetch_c = c;
            if (req_log[c] && addr_log[c] == 32'h0) zero_fetches++;
        end
        for (int c = 1; c < fetch_c; c++) if (ret_log[c]) rets++;
        checks++;
        if (fetch_c !== 34 || rets !== 9) begin
            errors++; $display("FAIL loop_exit: got fetch@0xC cycle=%0d retires=%0d expected 34/9", fetch_c, rets);
        end
        checks++;
        if (zero_fetches !== 3) begin
            errors++; $display("FAIL loop_taken: got %0d fetches at 0 expected 3", zero_fetches);
        end
        checks++;
        if (a0_log[34] !== 32'h3) begin
            errors++; $display("FAIL loop_a0: got %h expected 00000003", a0_log[34]);
        end
    endtask

    task automatic test_alu_jump();
        int skipped = 0;
        clear_prog();
        prog[0] = 32'h123452B7;             // lui  x5,0x12345
        prog[1] = 32'h67800313;             // addi x6,x0,0x678
        prog[2] = 32'h00628533;             // add  x10,x5,x6
        prog[3] = 32'h406005B3;             // sub  x11,x0,x6
        prog[4] = 32'h008000EF;             // jal  x1,+8
        prog[5] = 32'h00000513;             // addi x10,x0,0 (jumped over)
        prog[6] = 32'h00B50533;             // add  x10,x10,x11
        prog[7] = 32'h00000063;             // beq  x0,x0,0
        do_reset();
        run_trace(30);
        checks++;
        if (a0_log[13] !== 32'h12345678) begin
            errors++; $display("FAIL lui_add: got %h expected 12345678", a0_log[13]);
        end
        for (int c = 1; c <= 30; c++) if (req_log[c] && addr_log[c] == 32'h14) skipped++;
        checks++;
        if (skipped !== 0 || ret_log[20] !== 1'b1 || req_log[21] !== 1'b1 || addr_log[21] !== 32'h18) begin
            errors++; $display("FAIL jal_target: got fetches@0x14=%0d ret20=%0b addr21=%h expected 0/1/00000018",
                               skipped, ret_log[20], addr_log[21]);
        end
        checks++;
        if (a0_log[25] !== 32'h12345000) begin
            errors++; $display("FAIL sub_add: got %h expected 12345000", a0_log[25]);
        end
        checks++;
        if (ret_log[26] !== 1'b0 || ret_log[27] !== 1'b1 || req_log[28] !== 1'b1 || addr_log[28] !== 32'h1C) begin
            errors++; $display("FAIL beq_self: got ret26=%0b ret27=%0b addr28=%h expected 0/1/0000001c",
                               ret_log[26], ret_log[27], addr_log[28]);
        end
    endtask

    task automatic test_halt();
        logic [31:0] instr [4];
        int          exp_at [4];
        instr[0] = 32'h00000000; exp_at[0] = 3;   // illegal opcode
        instr[1] = 32'h00202503; exp_at[1] = 4;   // lw x10,2(x0) misaligned
        instr[2] = 32'h00000163; exp_at[2] = 4;   // beq x0,x0,+2 misaligned
        instr[3] = 32'h0020056F; exp_at[3] = 5;   // jal x10,+2 misaligned
        for (int t = 0; t < 4; t++) begin
            int first = 0;
            int rets = 0;
            int late_req = 0;
            clear_prog();
            prog[0] = instr[t];
            do_reset();
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0 || halted !== 1'b0) begin
                errors++; $display("FAIL halt%0d_resume: got req=%0b addr=%h halt=%0b expected 1/0/0",
                                   t, bus.mem_req, bus.mem_addr, halted);
            end
            run_trace(8);
            for (int c = 1; c <= 8; c++) begin
                if (halt_log[c] && first == 0) first = c;
                if (ret_log[c]) rets++;
                if (c >= 2 && req_log[c]) late_req++;
            end
            checks++;
            if (first !== exp_at[t] || !halt_log[8]) begin
                errors++; $display("FAIL halt%0d_cycle: got %0d sticky=%0b expected %0d/1",
                                   t, first, halt_log[8], exp_at[t]);
            end
            checks++;
            if (rets !== 0 || late_req !== 0 || a0_log[8] !== 32'h0) begin
                errors++; $display("FAIL halt%0d_quiet: got retires=%0d reqs=%0d a0=%h expected 0/0/0",
                                   t, rets, late_req, a0_log[8]);
            end
        end
    endtask

    task automatic test_rv32e();
        int r32 = 0;
        int r16 = 0;
        int h16_at = 0;
        clear_prog();
        prog[0] = 32'h00100A13;             // addi x20,x0,1
        rdata16 = 32'h00100A13;
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            if (retire) r32++;
            if (retire16) r16++;
            if (halted16 && h16_at == 0) h16_at = c;
            @(negedge clk); #1;
        end
        checks++;
        if (h16_at !== 3 || r16 !== 0 || bus16.mem_req !== 1'b0) begin
            errors++; $display("FAIL rv32e_x20_halt: got halt@%0d retires=%0d req=%0b expected 3/0/0",
                               h16_at, r16, bus16.mem_req);
        end
        checks++;
        if (r32 !== 1 || halted !== 1'b0) begin
            errors++; $display("FAIL rv32i_x20_ok: got retires=%0d halt=%0b expected 1/0", r32, halted);
        end
        rdata16 = 32'h00500513;
        do_reset();
        r16 = 0;
        for (int c = 1; c <= 6; c++) begin
            if (retire16) r16++;
            @(negedge clk); #1;
        end
        checks++;
        if (r16 !== 1 || a0_16 !== 32'h5 || halted16 !== 1'b0) begin
            errors++; $display("FAIL rv32e_x10_ok: got retires=%0d a0=%h halt=%0b expected 1/00000005/0",
                               r16, a0_16, halted16);
        end
    endtask

    initial begin
        stall_cycles = 0;
        rdata16 = 32'h00000013;
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
        clear_prog();
        test_reset();
        test_addi();
        test_store_load();
        test_wait_states();
        test_loop();
        test_alu_jump();
        test_halt();
        test_rv32e();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
